// File: rtl/color_detect_pkg.sv
// Shared encodings and default thresholds for the colour detector stream.
package color_detect_pkg;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_RED   = 2'd1,
        CLS_GREEN = 2'd2,
        CLS_BLUE  = 2'd3
    } color_class_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_e;

    localparam int DEF_HI_THR = 150;
    localparam int DEF_LO_THR = 100;

endpackage

// File: rtl/color_detect_stream_classify.sv
// Combinational pixel classifier: one dominant component at/above hi, the others at/below lo.
module color_classify
    import color_detect_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] hi_i,
    input  logic [PIX_W-1:0] lo_i,
    output color_class_e     cls_o
);

    logic r_hi, g_hi, b_hi;
    logic r_lo, g_lo, b_lo;

    assign r_hi = (r_i >= hi_i);
    assign g_hi = (g_i >= hi_i);
    assign b_hi = (b_i >= hi_i);
    assign r_lo = (r_i <= lo_i);
    assign g_lo = (g_i <= lo_i);
    assign b_lo = (b_i <= lo_i);

    // Priority order only matters if runtime thresholds ever make hi <= lo.
    always_comb begin
        cls_o = CLS_NONE;
        if (r_hi && g_lo && b_lo) begin
            cls_o = CLS_RED;
        end else if (g_hi && r_lo && b_lo) begin
            cls_o = CLS_GREEN;
        end else if (b_hi && r_lo && g_lo) begin
            cls_o = CLS_BLUE;
        end
    end

endmodule

// File: rtl/color_detect_stream.sv
// Streaming colour detector: per-pixel class, persistence flags and per-frame counts.
// Define COLOR_DETECT_RUNTIME_THR_EN to add hi_thr/lo_thr inputs sampled on each sof pixel.
module color_detect_stream
    import color_detect_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int HI_THR  = DEF_HI_THR,
    parameter int LO_THR  = DEF_LO_THR,
    parameter int PERSIST = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic [PIX_W-1:0] r_in,
    input  logic [PIX_W-1:0] g_in,
    input  logic [PIX_W-1:0] b_in,
`ifdef COLOR_DETECT_RUNTIME_THR_EN
    input  logic [PIX_W-1:0] hi_thr,
    input  logic [PIX_W-1:0] lo_thr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic             red_detected,
    output logic             green_detected,
    output logic             blue_detected,
    output logic [CNT_W-1:0] red_count,
    output logic [CNT_W-1:0] green_count,
    output logic [CNT_W-1:0] blue_count,
    output logic             stats_valid,
    output logic             sof_err,
    output frame_state_e     dbg_state_o
);

    localparam logic [PIX_W-1:0] HI_C    = PIX_W'(HI_THR);
    localparam logic [PIX_W-1:0] LO_C    = PIX_W'(LO_THR);
    localparam logic [7:0]       PERS_C  = 8'(PERSIST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a pixel moves when in_valid && in_ready; the output beat moves when
    // out_valid && out_ready. The single output register frees up whenever it drains.
    logic             out_valid_q;
    color_class_e     out_class_q;
    logic             accept;
    logic [PIX_W-1:0] hi_use, lo_use;
    color_class_e     pix_cls;
    logic [2:0]       hit;

    assign in_ready = out_ready || !out_valid_q;
    assign accept   = in_valid && in_ready;

`ifdef COLOR_DETECT_RUNTIME_THR_EN
    logic [PIX_W-1:0] hi_q, lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= HI_C;
            lo_q <= LO_C;
        end else if (accept && in_sof) begin
            hi_q <= hi_thr;
            lo_q <= lo_thr;
        end
    end

    // The sof pixel itself is judged with the freshly presented thresholds.
    assign hi_use = in_sof ? hi_thr : hi_q;
    assign lo_use = in_sof ? lo_thr : lo_q;
`else
    assign hi_use = HI_C;
    assign lo_use = LO_C;
`endif

    color_classify #(.PIX_W(PIX_W)) u_classify (
        .r_i  (r_in),
        .g_i  (g_in),
        .b_i  (b_in),
        .hi_i (hi_use),
        .lo_i (lo_use),
        .cls_o(pix_cls)
    );

    assign hit = {pix_cls == CLS_BLUE, pix_cls == CLS_GREEN, pix_cls == CLS_RED};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_class_q <= CLS_NONE;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_class_q <= pix_cls;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    logic [2:0][7:0] match_q, match_d, miss_q, miss_d;
    logic [2:0]      det_q, det_d;

    always_comb begin
        match_d = match_q;
        miss_d  = miss_q;
        det_d   = det_q;
        if (accept) begin
            for (int c = 0; c < 3; c++) begin
                if (hit[c]) begin
                    miss_d[c]  = '0;
                    match_d[c] = (match_q[c] >= PERS_C) ? PERS_C : match_q[c] + 8'd1;
                    if (match_d[c] == PERS_C) det_d[c] = 1'b1;
                end else begin
                    match_d[c] = '0;
                    miss_d[c]  = (miss_q[c] >= PERS_C) ? PERS_C : miss_q[c] + 8'd1;
                    if (miss_d[c] == PERS_C) det_d[c] = 1'b0;
                end
            end
        end
    end

    frame_state_e         state_q, state_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                 stats_q, stats_d, sof_err_q, sof_err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stats_d   = 1'b0;
        sof_err_d = 1'b0;
        if (accept) begin
            if (in_sof) begin
                // A new sof always restarts counting; an open frame is simply dropped.
                sof_err_d = (state_q == ST_IN_FRAME);
                for (int c = 0; c < 3; c++) cnt_d[c] = CNT_W'(hit[c]);
                state_d = in_eof ? ST_IDLE : ST_IN_FRAME;
                stats_d = in_eof;
            end else if (state_q == ST_IN_FRAME) begin
                for (int c = 0; c < 3; c++) begin
                    if (hit[c] && cnt_q[c] != CNT_MAX) cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
                if (in_eof) begin
                    state_d = ST_IDLE;
                    stats_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q   <= '0;
            miss_q    <= '0;
            det_q     <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stats_q   <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            match_q   <= match_d;
            miss_q    <= miss_d;
            det_q     <= det_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stats_q   <= stats_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_class      = out_class_q;
    assign red_detected   = det_q[0];
    assign green_detected = det_q[1];
    assign blue_detected  = det_q[2];
    assign red_count      = cnt_q[0];
    assign green_count    = cnt_q[1];
    assign blue_count     = cnt_q[2];
    assign stats_valid    = stats_q;
    assign sof_err        = sof_err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_color_detect_stream.sv
// Self-checking bench for color_detect_stream; output classes go through an expected queue.
module tb_color_detect_stream;
    import color_detect_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_sof, in_eof;
    logic [7:0]       r_in, g_in, b_in;
    logic             out_valid, out_ready;
    logic [1:0]       out_class;
    logic             red_detected, green_detected, blue_detected;
    logic [CNT_W-1:0] red_count, green_count, blue_count;
    logic             stats_valid, sof_err;
    frame_state_e     dbg_state;
`ifdef COLOR_DETECT_RUNTIME_THR_EN
    logic [7:0]       hi_thr, lo_thr;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];

    color_detect_stream #(.PIX_W(8), .PERSIST(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sof        (in_sof),
        .in_eof        (in_eof),
        .r_in          (r_in),
        .g_in          (g_in),
        .b_in          (b_in),
`ifdef COLOR_DETECT_RUNTIME_THR_EN
        .hi_thr        (hi_thr),
        .lo_thr        (lo_thr),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_class     (out_class),
        .red_detected  (red_detected),
        .green_detected(green_detected),
        .blue_detected (blue_detected),
        .red_count     (red_count),
        .green_count   (green_count),
        .blue_count    (blue_count),
        .stats_valid   (stats_valid),
        .sof_err       (sof_err),
        .dbg_state_o   (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_cls(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if (r >= 8'd150 && g <= 8'd100 && b <= 8'd100) return 2'd1;
        if (g >= 8'd150 && r <= 8'd100 && b <= 8'd100) return 2'd2;
        if (b >= 8'd150 && r <= 8'd100 && g <= 8'd100) return 2'd3;
        return 2'd0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
    endtask

    // Driver: present a pixel, wait (bounded) for acceptance, return 1 time unit after that edge.
    task automatic drive_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic sof, input logic eof, input logic [1:0] exp_cls);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        r_in = r;
        g_in = g;
        b_in = b;
        in_sof = sof;
        in_eof = eof;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", in_ready, 1);
        else exp_q.push_back(exp_cls);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
    endtask

    // Scoreboard: pop on every output handshake; a stalled beat must not change.
    logic       stall_prev = 1'b0;
    logic [1:0] stall_cls = 2'd0;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_class", out_class, stall_cls);
            end
            if (out_valid && out_ready) begin
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("out_class", out_class, exp_q.pop_front());
            end
            stall_prev <= out_valid && !out_ready;
            stall_cls <= out_class;
        end
    end

    task automatic check_counts(input string tag, input int r, input int g, input int b);
        check_eq({tag, "_red_cnt"}, red_count, r);
        check_eq({tag, "_green_cnt"}, green_count, g);
        check_eq({tag, "_blue_cnt"}, blue_count, b);
    endtask

    initial begin
        int er, eg, eb, drained;
        logic done;
        logic [7:0] pr, pg, pb;
        logic [1:0] pc;

        reset = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        out_ready = 1'b1;
`ifdef COLOR_DETECT_RUNTIME_THR_EN
        hi_thr = 8'd150;
        lo_thr = 8'd100;
`endif
        do_reset();

        // Reset state
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_class", out_class, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_flags", {red_detected, green_detected, blue_detected}, 0);
        check_counts("rst", 0, 0, 0);
        check_eq("rst_stats_valid", stats_valid, 0);
        check_eq("rst_sof_err", sof_err, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);

        // Red frame of four plus a dark eof pixel
        drive_pix(8'd200, 8'd50, 8'd50, 1'b1, 1'b0, 2'd1);
        check_eq("t1_det_p1", red_detected, 0);
        check_eq("t1_state", dbg_state, ST_IN_FRAME);
        drive_pix(8'd200, 8'd50, 8'd50, 1'b0, 1'b0, 2'd1);
        drive_pix(8'd200, 8'd50, 8'd50, 1'b0, 1'b0, 2'd1);
        check_eq("t1_det_p3", red_detected, 0);
        drive_pix(8'd200, 8'd50, 8'd50, 1'b0, 1'b0, 2'd1);
        check_eq("t1_det_p4", red_detected, 1);
        drive_pix(8'd10, 8'd10, 8'd10, 1'b0, 1'b1, 2'd0);
        check_eq("t1_stats_pulse", stats_valid, 1);
        check_counts("t1", 4, 0, 0);
        check_eq("t1_det_after_eof", red_detected, 1);
        wait_cycles(1);
        check_eq("t1_stats_end", stats_valid, 0);
        check_counts("t1_held", 4, 0, 0);

        // Persistence: three misses keep the flag, the fourth clears it
        do_reset();
        for (int i = 0; i < 4; i++) drive_pix(8'd200, 8'd50, 8'd50, 1'b0, 1'b0, 2'd1);
        check_eq("t2_det_set", red_detected, 1);
        check_eq("t2_idle_no_count", red_count, 0);
        for (int i = 0; i < 3; i++) begin
            drive_pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'd0);
            check_eq("t2_det_hold", red_detected, 1);
        end
        drive_pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'd0);
        check_eq("t2_det_clear", red_detected, 0);

        // Backpressure: hold one beat for five cycles with a pixel waiting
        drive_pix(8'd200, 8'd50, 8'd50, 1'b1, 1'b0, 2'd1);
        out_ready = 1'b0;
        fork
            drive_pix(8'd50, 8'd200, 8'd50, 1'b0, 1'b0, 2'd2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check_eq("t3_in_ready_low", in_ready, 0);
                    check_eq("t3_held_class", out_class, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drive_pix(8'd50, 8'd50, 8'd200, 1'b0, 1'b1, 2'd3);
        check_eq("t3_stats", stats_valid, 1);
        check_counts("t3", 1, 1, 1);

        // Threshold boundaries and a one-pixel frame
        drive_pix(8'd150, 8'd100, 8'd100, 1'b0, 1'b0, 2'd1);
        drive_pix(8'd149, 8'd100, 8'd100, 1'b0, 1'b0, 2'd0);
        drive_pix(8'd150, 8'd101, 8'd100, 1'b0, 1'b0, 2'd0);
        drive_pix(8'd100, 8'd150, 8'd100, 1'b0, 1'b0, 2'd2);
        drive_pix(8'd0, 8'd0, 8'd150, 1'b1, 1'b1, 2'd3);
        check_eq("t4_stats", stats_valid, 1);
        check_counts("t4", 0, 0, 1);
        check_eq("t4_state", dbg_state, ST_IDLE);

        // Second sof mid-frame, then reset mid-frame with a held beat
        drive_pix(8'd200, 8'd50, 8'd50, 1'b1, 1'b0, 2'd1);
        check_eq("t5_no_err_first", sof_err, 0);
        drive_pix(8'd50, 8'd200, 8'd50, 1'b0, 1'b0, 2'd2);
        drive_pix(8'd50, 8'd50, 8'd200, 1'b1, 1'b0, 2'd3);
        check_eq("t5_sof_err", sof_err, 1);
        check_eq("t5_no_stats", stats_valid, 0);
        drive_pix(8'd50, 8'd200, 8'd50, 1'b0, 1'b1, 2'd2);
        check_eq("t5_sof_err_end", sof_err, 0);
        check_eq("t5_stats", stats_valid, 1);
        check_counts("t5", 0, 1, 1);

        drive_pix(8'd200, 8'd50, 8'd50, 1'b1, 1'b0, 2'd1);
        drive_pix(8'd200, 8'd50, 8'd50, 1'b0, 1'b0, 2'd1);
        out_ready = 1'b0;
        reset = 1'b1;
        wait_cycles(1);
        check_eq("t5_rst_out_valid", out_valid, 0);
        check_counts("t5_rst", 0, 0, 0);
        check_eq("t5_rst_stats", stats_valid, 0);
        check_eq("t5_rst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            check_eq("t5_post_rst_stats", stats_valid, 0);
            check_eq("t5_post_rst_valid", out_valid, 0);
        end

        // Random frame under random backpressure
        do_reset();
        er = 0;
        eg = 0;
        eb = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    pr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(90, 160));
                    pg = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(90, 160));
                    pb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(90, 160));
                    pc = model_cls(pr, pg, pb);
                    if (pc == 2'd1) er++;
                    if (pc == 2'd2) eg++;
                    if (pc == 2'd3) eb++;
                    drive_pix(pr, pg, pb, i == 0, i == 39, pc);
                end
                check_eq("rand_stats", stats_valid, 1);
                check_counts("rand", er, eg, eb);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join

`ifdef COLOR_DETECT_RUNTIME_THR_EN
        // Runtime thresholds are taken on sof and held for the frame
        do_reset();
        hi_thr = 8'd200;
        lo_thr = 8'd50;
        drive_pix(8'd180, 8'd40, 8'd40, 1'b1, 1'b0, 2'd0);
        hi_thr = 8'd150;
        lo_thr = 8'd100;
        drive_pix(8'd180, 8'd40, 8'd40, 1'b0, 1'b0, 2'd0);
        drive_pix(8'd10, 8'd10, 8'd10, 1'b0, 1'b1, 2'd0);
        check_counts("thr_strict", 0, 0, 0);
        drive_pix(8'd180, 8'd40, 8'd40, 1'b1, 1'b1, 2'd1);
        check_counts("thr_relaxed", 1, 0, 0);
`endif

        // Drain the scoreboard
        out_ready = 1'b1;
        drained = 0;
        while (exp_q.size() > 0 && drained < 20) begin
            wait_cycles(1);
            drained++;
        end
        wait_cycles(2);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
